// File: rtl/systolic_mm_array.sv
`default_nettype none
// ============================================================================
// Module   : systolic_mm_array
// Brief    : SIZE x SIZE output-stationary systolic matrix multiplier.
//            Loads K beats of (A column, B row), skews operands internally,
//            flushes, then streams C = A x B out row-major via valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
module systolic_mm_array #(
    parameter int SIZE   = 4,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32,
    parameter int K_W    = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [K_W-1:0]               k_len,
    input  logic                         signed_mode,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [SIZE*DATA_W-1:0]       a_col,
    input  logic [SIZE*DATA_W-1:0]       b_row,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [ACC_W-1:0]             out_data,
    output logic [$clog2(SIZE*SIZE)-1:0] out_idx,
    output logic                         out_last,
    output logic                         busy,
    output logic                         done
);

    localparam int c_IDX_W = $clog2(SIZE*SIZE);
    localparam int c_FL_W  = $clog2(2*SIZE);
    localparam logic [c_FL_W-1:0]  c_FL_LAST  = c_FL_W'(2*SIZE-2);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(SIZE*SIZE-1);

    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_LOAD  = 2'd1;
    localparam logic [1:0] c_S_FLUSH = 2'd2;
    localparam logic [1:0] c_S_DRAIN = 2'd3;

    logic [1:0]         r_state, w_state_nx;
    logic [K_W-1:0]     r_k_len, r_beat;
    logic               r_signed;
    logic [c_FL_W-1:0]  r_flush_cnt;
    logic [c_IDX_W-1:0] r_out_idx;
    logic               r_done;

    logic w_clr, w_beat_ok, w_last_beat, w_out_hs, w_out_fin, w_acc_en;

    logic [DATA_W-1:0] w_a_in [SIZE];
    logic [DATA_W-1:0] w_b_in [SIZE];
    logic [DATA_W-1:0] w_a_h  [SIZE][SIZE];   // a entering PE(i,j)
    logic [DATA_W-1:0] w_b_v  [SIZE][SIZE];   // b entering PE(i,j)
    logic [ACC_W-1:0]  w_acc  [SIZE*SIZE];

    assign w_clr       = (r_state == c_S_IDLE) && start;
    assign w_beat_ok   = (r_state == c_S_LOAD) && in_valid;
    assign w_last_beat = w_beat_ok && (r_beat == r_k_len - K_W'(1));
    assign w_out_hs    = (r_state == c_S_DRAIN) && out_ready;
    assign w_out_fin   = w_out_hs && (r_out_idx == c_IDX_LAST);
    assign w_acc_en    = (r_state == c_S_LOAD) || (r_state == c_S_FLUSH);

    assign in_ready  = (r_state == c_S_LOAD);
    assign out_valid = (r_state == c_S_DRAIN);
    assign out_data  = (r_state == c_S_DRAIN) ? w_acc[r_out_idx] : '0;
    assign out_idx   = r_out_idx;
    assign out_last  = (r_state == c_S_DRAIN) && (r_out_idx == c_IDX_LAST);
    assign busy      = (r_state != c_S_IDLE);
    assign done      = r_done;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= c_S_IDLE;
        else       r_state <= w_state_nx;
    end

    // Next-state decode
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            c_S_IDLE:  if (start) w_state_nx = (k_len != '0) ? c_S_LOAD : c_S_DRAIN;
            c_S_LOAD:  if (w_last_beat) w_state_nx = c_S_FLUSH;
            c_S_FLUSH: if (r_flush_cnt == c_FL_LAST) w_state_nx = c_S_DRAIN;
            c_S_DRAIN: if (w_out_fin) w_state_nx = c_S_IDLE;
            default:   w_state_nx = c_S_IDLE;
        endcase
    end

    // Tile configuration, beat/flush/output counters and done pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_k_len     <= '0;
            r_signed    <= 1'b0;
            r_beat      <= '0;
            r_flush_cnt <= '0;
            r_out_idx   <= '0;
            r_done      <= 1'b0;
        end else begin
            r_done <= w_out_fin;
            if (w_clr) begin
                r_k_len   <= k_len;
                r_signed  <= signed_mode;
                r_beat    <= '0;
                r_out_idx <= '0;
            end
            if (w_beat_ok) r_beat <= r_beat + K_W'(1);
            if (r_state == c_S_FLUSH) r_flush_cnt <= r_flush_cnt + c_FL_W'(1);
            else                      r_flush_cnt <= '0;
            if (w_out_hs) r_out_idx <= w_out_fin ? '0 : r_out_idx + c_IDX_W'(1);
        end
    end

    // Operand injection (zeros on bubbles and outside LOAD) and input skew
    for (genvar gi = 0; gi < SIZE; gi++) begin : g_edge
        assign w_a_in[gi] = w_beat_ok ? a_col[gi*DATA_W +: DATA_W] : '0;
        assign w_b_in[gi] = w_beat_ok ? b_row[gi*DATA_W +: DATA_W] : '0;

        if (gi == 0) begin : g_nodly
            assign w_a_h[0][0] = w_a_in[0];
            assign w_b_v[0][0] = w_b_in[0];
        end else begin : g_dly
            logic [DATA_W-1:0] r_a_sk [gi];
            logic [DATA_W-1:0] r_b_sk [gi];

            // gi-stage delay line for row gi of A and column gi of B
            always_ff @(posedge clk or posedge reset) begin
                if (reset || w_clr) begin
                    for (int k = 0; k < gi; k++) begin
                        r_a_sk[k] <= '0;
                        r_b_sk[k] <= '0;
                    end
                end else begin
                    r_a_sk[0] <= w_a_in[gi];
                    r_b_sk[0] <= w_b_in[gi];
                    for (int k = 1; k < gi; k++) begin
                        r_a_sk[k] <= r_a_sk[k-1];
                        r_b_sk[k] <= r_b_sk[k-1];
                    end
                end
            end

            assign w_a_h[gi][0] = r_a_sk[gi-1];
            assign w_b_v[0][gi] = r_b_sk[gi-1];
        end
    end

    // Processing element grid
    for (genvar gi = 0; gi < SIZE; gi++) begin : g_row
        for (genvar gj = 0; gj < SIZE; gj++) begin : g_col
            logic signed [2*DATA_W-1:0] w_ps;
            logic        [2*DATA_W-1:0] w_pu;
            logic        [ACC_W-1:0]    w_prod;
            logic        [ACC_W-1:0]    r_acc;

            assign w_ps   = (2*DATA_W)'($signed(w_a_h[gi][gj])) * (2*DATA_W)'($signed(w_b_v[gi][gj]));
            assign w_pu   = (2*DATA_W)'(w_a_h[gi][gj]) * (2*DATA_W)'(w_b_v[gi][gj]);
            assign w_prod = r_signed ? ACC_W'(w_ps) : ACC_W'(w_pu);
            assign w_acc[gi*SIZE+gj] = r_acc;

            // Output-stationary accumulator, wraps modulo 2^ACC_W
            always_ff @(posedge clk or posedge reset) begin
                if (reset)         r_acc <= '0;
                else if (w_clr)    r_acc <= '0;
                else if (w_acc_en) r_acc <= r_acc + w_prod;
            end

            if (gj < SIZE-1) begin : g_fwd_a
                logic [DATA_W-1:0] r_a;
                // One-cycle hop of a to the right neighbour
                always_ff @(posedge clk or posedge reset) begin
                    if (reset || w_clr) r_a <= '0;
                    else                r_a <= w_a_h[gi][gj];
                end
                assign w_a_h[gi][gj+1] = r_a;
            end

            if (gi < SIZE-1) begin : g_fwd_b
                logic [DATA_W-1:0] r_b;
                // One-cycle hop of b to the neighbour below
                always_ff @(posedge clk or posedge reset) begin
                    if (reset || w_clr) r_b <= '0;
                    else                r_b <= w_b_v[gi][gj];
                end
                assign w_b_v[gi+1][gj] = r_b;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_systolic_mm_array.sv
`default_nettype none
// ============================================================================
// Module   : tb_systolic_mm_array
// Brief    : Self-checking bench for systolic_mm_array (SIZE=4, 8-bit, 32-bit
//            accumulators). Reference matrix product feeds a result scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_systolic_mm_array;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  k_len;
    logic        signed_mode;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a_col;
    logic [31:0] b_row;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [3:0]  out_idx;
    logic        out_last;
    logic        busy;
    logic        done;

    systolic_mm_array #(.SIZE(4), .DATA_W(8), .ACC_W(32), .K_W(8)) dut (
        .clk(clk), .reset(reset), .start(start), .k_len(k_len),
        .signed_mode(signed_mode), .in_valid(in_valid), .in_ready(in_ready),
        .a_col(a_col), .b_row(b_row), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx),
        .out_last(out_last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        int          idx;
        bit          last;
    } sb_t;

    typedef struct {
        int          pat;        // 0 identity/1..16, 1 0xFF/0x02, 2 random, 3 empty
        int          k;
        bit          sgn;
        int          gap;        // 1: in_valid low on alternate LOAD cycles
        int          rdy;        // 0 always, 1 pattern 1,0,0,1, 2 random
        bit          dstart;     // assert start during DRAIN
        int          exp_load;   // expected LOAD cycle count
        bit          has_first;
        logic [31:0] first;      // expected C[0][0]
    } vec_t;

    sb_t         sb_q[$];
    vec_t        vecs[8];
    logic [7:0]  am[4][16];
    logic [7:0]  bm[16][4];
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic set_pat(input int pat, input int k);
        for (int i = 0; i < 4; i++)
            for (int kk = 0; kk < 16; kk++) begin
                case (pat)
                    0:       begin am[i][kk] = (i == kk) ? 8'd1 : 8'd0; bm[kk][i] = 8'(kk*4 + i + 1); end
                    1:       begin am[i][kk] = 8'hFF; bm[kk][i] = 8'h02; end
                    2:       begin am[i][kk] = 8'($urandom); bm[kk][i] = 8'($urandom); end
                    default: begin am[i][kk] = 8'h00; bm[kk][i] = 8'h00; end
                endcase
            end
        // reference product into the scoreboard
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                logic [31:0] sum;
                int sa, sb;
                sum = 32'd0;
                for (int kk = 0; kk < k; kk++) begin
                    sa = signed_mode ? int'($signed(am[r][kk])) : int'(am[r][kk]);
                    sb = signed_mode ? int'($signed(bm[kk][c])) : int'(bm[kk][c]);
                    sum = sum + 32'(sa * sb);
                end
                sb_q.push_back('{sum, r*4 + c, (r*4 + c) == 15});
            end
    endtask

    // One complete tile: start, LOAD, FLUSH, DRAIN, with scoreboard checks
    task automatic run_tile(input vec_t v);
        int  beat, load_cyc, done_cnt, post, dc, cyc, first_seen;
        bit  tog, stalled;
        logic [31:0] h_data;
        logic [3:0]  h_idx;
        bit  pat4 [4];
        pat4 = '{1'b1, 1'b0, 1'b0, 1'b1};
        signed_mode = v.sgn;
        set_pat(v.pat, v.k);
        start = 1'b1; k_len = 8'(v.k);
        @(posedge clk); #1;
        start = 1'b0; k_len = 8'($urandom); signed_mode = ~v.sgn;
        beat = 0; load_cyc = 0; done_cnt = 0; post = 0; dc = 0; cyc = 0;
        first_seen = 0; tog = 1'b0; stalled = 1'b0; h_data = '0; h_idx = '0;
        while (post < 4) begin
            if (cyc++ > 600) begin
                check("tile_timeout", 64'(cyc), 64'd0);
                break;
            end
            if (in_ready) begin
                load_cyc++;
                in_valid = (v.gap == 0) ? 1'b1 : tog;
                tog = ~tog;
                if (in_valid && beat < v.k) begin
                    for (int i = 0; i < 4; i++) begin
                        a_col[i*8 +: 8] = am[i][beat];
                        b_row[i*8 +: 8] = bm[beat][i];
                    end
                    beat++;
                end else begin
                    a_col = $urandom; b_row = $urandom;
                end
            end else begin
                in_valid = $urandom_range(0, 1);
                a_col = $urandom; b_row = $urandom;
            end
            if (out_valid) begin
                if (stalled) begin
                    check("hold_data", 64'(out_data), 64'(h_data));
                    check("hold_idx", 64'(out_idx), 64'(h_idx));
                end
                case (v.rdy)
                    0:       out_ready = 1'b1;
                    1:       out_ready = pat4[dc % 4];
                    default: out_ready = $urandom_range(0, 1);
                endcase
                dc++;
                start = v.dstart;
                k_len = 8'd5;
                if (out_ready) begin
                    stalled = 1'b0;
                    if (sb_q.size() == 0) begin
                        check("extra_result", 64'(out_idx), 64'hFFFF);
                    end else begin
                        sb_t e;
                        e = sb_q.pop_front();
                        check("data", 64'(out_data), 64'(e.d));
                        check("idx_last", {59'd0, out_idx, out_last}, {59'd0, 4'(e.idx), e.last});
                        if (first_seen == 0 && v.has_first)
                            check("first_value", 64'(out_data), 64'(v.first));
                        first_seen = 1;
                    end
                end else begin
                    stalled = 1'b1; h_data = out_data; h_idx = out_idx;
                end
            end else begin
                out_ready = $urandom_range(0, 1);
                start = 1'b0;
            end
            if (done) done_cnt++;
            if (done_cnt > 0) post++;
            @(posedge clk); #1;
        end
        start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        check("load_cycles", 64'(load_cyc), 64'(v.exp_load));
        check("done_pulses", 64'(done_cnt), 64'd1);
        check("sb_empty", 64'(sb_q.size()), 64'd0);
        check("idle_after", {62'd0, busy, out_valid}, 64'd0);
        sb_q.delete();
    endtask

    initial begin
        vecs[0] = '{0, 4, 1'b0, 0, 0, 1'b0, 4,  1'b1, 32'd1};
        vecs[1] = '{1, 1, 1'b1, 0, 0, 1'b0, 1,  1'b1, 32'hFFFF_FFFE};
        vecs[2] = '{1, 1, 1'b0, 0, 0, 1'b0, 1,  1'b1, 32'd510};
        vecs[3] = '{0, 4, 1'b0, 1, 0, 1'b0, 8,  1'b1, 32'd1};
        vecs[4] = '{0, 4, 1'b0, 0, 1, 1'b0, 4,  1'b1, 32'd1};
        vecs[5] = '{3, 0, 1'b0, 0, 0, 1'b1, 0,  1'b1, 32'd0};
        vecs[6] = '{2, 7, 1'b1, 1, 2, 1'b0, 14, 1'b0, 32'd0};
        vecs[7] = '{2, 5, 1'b0, 0, 2, 1'b0, 5,  1'b0, 32'd0};

        reset = 1'b1; start = 1'b0; k_len = '0; signed_mode = 1'b0;
        in_valid = 1'b0; a_col = '0; b_row = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_flags", {59'd0, in_ready, out_valid, out_last, busy, done}, 64'd0);
        check("rst_data", 64'(out_data), 64'd0);
        check("rst_idx", 64'(out_idx), 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        for (int t = 0; t < 8; t++) run_tile(vecs[t]);

        // Abort a tile after two LOAD beats, then a clean identity tile
        signed_mode = 1'b0;
        set_pat(0, 4);
        sb_q.delete();
        start = 1'b1; k_len = 8'd4;
        @(posedge clk); #1;
        start = 1'b0;
        for (int b = 0; b < 2; b++) begin
            in_valid = 1'b1;
            for (int i = 0; i < 4; i++) begin
                a_col[i*8 +: 8] = 8'hA5;
                b_row[i*8 +: 8] = 8'h5A;
            end
            @(posedge clk); #1;
        end
        check("abort_loading", {63'd0, busy}, 64'd1);
        reset = 1'b1; in_valid = 1'b0;
        #1;
        check("abort_busy", {62'd0, busy, in_ready}, 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        run_tile(vecs[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/systolic_mm_array.md
Name: systolic_mm_array

Overview:
- Parameterised successor to the fixed 4x4 8-bit MAC grid: a SIZE x SIZE output-stationary systolic array with its own sequencing FSM.
- Accepts one column of A and one row of B per beat over K beats, computes C = A x B, and skews operands internally.
- Flushes the pipeline, then streams the SIZE*SIZE accumulators out row-major over a valid/ready port.
- Sits between the operand buffers and the result writeback in the matrix processor datapath.

Parameters:
- SIZE, 4: array dimension; the block computes a SIZE x SIZE result tile.
- DATA_W, 8: operand element width.
- ACC_W, 32: accumulator and result width; must be at least 2*DATA_W.
- K_W, 8: width of k_len; maximum inner dimension is 2^K_W - 1.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  begin a tile; sampled only in IDLE.
- k_len  in  K_W  inner dimension K; latched on start.
- signed_mode  in  1  1 = two's-complement operands, 0 = unsigned; latched on start.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  high only in LOAD.
- a_col  in  SIZE*DATA_W  A[i][k] in bits [i*DATA_W +: DATA_W].
- b_row  in  SIZE*DATA_W  B[k][j] in bits [j*DATA_W +: DATA_W].
- out_valid  out  1  result beat valid (DRAIN only).
- out_ready  in  1  result consumer ready.
- out_data  out  ACC_W  C[r][c].
- out_idx  out  $clog2(SIZE*SIZE)  r*SIZE+c of the current out_data.
- out_last  out  1  high with the final result beat.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse after the last result handshake.

Behaviour:
- Reset values: IDLE state; all accumulators, skew registers and PE pipeline registers 0; in_ready, out_valid, out_last, busy and done are 0; out_data = 0; out_idx = 0.
- States and transitions:
  - IDLE: on start, latch k_len and signed_mode and clear all accumulators. Go to LOAD if k_len != 0, otherwise go straight to DRAIN (result is all zeros).
  - LOAD: in_ready = 1. Each in_valid cycle is one accepted beat; the beat counter increments. A cycle without in_valid injects zero operands (a bubble), which leaves results unchanged. After beat k_len is accepted, go to FLUSH.
  - FLUSH: lasts exactly 2*SIZE-1 cycles, then go to DRAIN. in_ready = 0 and zeros are injected.
  - DRAIN: out_valid = 1 and out_data = acc[out_idx]. out_idx advances on out_valid && out_ready. out_last = 1 when out_idx = SIZE*SIZE-1. After the last handshake, return to IDLE and pulse done on the next cycle. out_data holds stable while out_ready = 0.
- Skew: row i of A is delayed by i cycles before entering column 0; column j of B is delayed by j cycles before entering row 0.
- PE(i,j) each cycle:
  - acc += a*b.
  - Forward a to PE(i,j+1) and b to PE(i+1,j) through registers, giving a one-cycle hop.
- Arithmetic:
  - The product is 2*DATA_W wide, sign- or zero-extended to ACC_W per the latched signed_mode.
  - Accumulation wraps modulo 2^ACC_W; there is no saturation.
- start is ignored outside IDLE; k_len and signed_mode changes mid-tile have no effect.
- Reset asserted mid-tile returns to IDLE immediately. The next tile must produce correct results with no residue from the aborted one.
- Simultaneous last LOAD beat and in_valid drop: no special case; the beat counter alone decides the LOAD -> FLUSH transition.

Test Plan:
- SIZE=4, K=4, A=identity, B=[1..16] row-major, unsigned, out_ready=1 -> out_data 1..16 in order, out_idx 0..15, out_last only on idx 15, done pulses once.
- SIZE=4, K=1, all a=0xFF, all b=0x02: signed_mode=1 -> all 16 results 0xFFFFFFFE; signed_mode=0 -> all 16 results 510.
- Repeat the identity test with in_valid low on alternate cycles during LOAD -> identical results; LOAD lasts 8 cycles.
- Identity test with out_ready toggling 1,0,0,1 -> every value appears exactly once, in order, and is held stable while stalled.
- start with k_len=0 -> no LOAD cycles, 16 zero results, done pulses; a start asserted during DRAIN is ignored.
- Assert reset after 2 LOAD beats, then run the identity test -> results 1..16 exactly; busy is 0 directly after reset.
